// File: rtl/calc_input_seq_if.sv
// calc_input_seq_if: switch/button inputs and latched A/B/OP valid/ready hand-off of the entry sequencer.
interface calc_input_seq_if;
  logic [7:0] SW;
  logic       BTN_N;
  logic       READY;
  logic [3:0] A;
  logic [3:0] B;
  logic [2:0] OP;
  logic       VALID;
  logic [1:0] STATE;
  modport master (input SW, BTN_N, READY, output A, B, OP, VALID, STATE);
  modport slave (output SW, BTN_N, READY, input A, B, OP, VALID, STATE);
endinterface

// File: rtl/calc_input_seq.sv
// calc_input_seq: button-driven A -> B -> OP entry sequencer presenting one operation per valid/ready hand-off.
// Define CALC_INPUT_SEQ_DEBOUNCE_EN to debounce BTN_N; otherwise any synchronized falling edge is an enter.
module calc_input_seq #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input logic CLOCK_50,
  input logic RESETN,
  calc_input_seq_if.master io
);
  typedef enum logic [1:0] {GET_A = 2'b00, GET_B = 2'b01, GET_OP = 2'b10, SEND = 2'b11} state_t;
  state_t     state_q, state_d;
  logic [3:0] a_q, a_d, b_q, b_d;
  logic [2:0] op_q, op_d;
  logic [7:0] sw_s1_q, sw_s2_q;
  logic       btn_s1_q, btn_s2_q;
  logic [1:0] settle_q, settle_d;
  logic       armed_q, armed_d;
  logic       enter;
  logic       sw_unused;
  assign sw_unused = ^sw_s2_q[7:4];
  always_ff @(posedge CLOCK_50 or negedge RESETN) begin
    if (!RESETN) begin
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      btn_s1_q <= 1'b1;
      btn_s2_q <= 1'b1;
    end else begin
      sw_s1_q  <= io.SW;
      sw_s2_q  <= sw_s1_q;
      btn_s1_q <= io.BTN_N;
      btn_s2_q <= btn_s1_q;
    end
  end
  // Enter is only armed once the synchronizer holds a real pin sample showing the button released.
  always_comb begin
    settle_d = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
    armed_d  = armed_q | ((settle_q == 2'd2) & btn_s2_q);
  end
  always_ff @(posedge CLOCK_50 or negedge RESETN) begin
    if (!RESETN) begin
      settle_q <= '0;
      armed_q  <= 1'b0;
    end else begin
      settle_q <= settle_d;
      armed_q  <= armed_d;
    end
  end
`ifdef CALC_INPUT_SEQ_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          db_q, db_d, enter_q, enter_d, flip;
  always_comb begin
    flip    = (btn_s2_q != db_q) && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
    cnt_d   = ((btn_s2_q == db_q) || flip) ? '0 : cnt_q + 1'b1;
    db_d    = flip ? btn_s2_q : db_q;
    enter_d = flip & ~btn_s2_q & armed_q;
  end
  always_ff @(posedge CLOCK_50 or negedge RESETN) begin
    if (!RESETN) begin
      cnt_q   <= '0;
      db_q    <= 1'b1;
      enter_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      db_q    <= db_d;
      enter_q <= enter_d;
    end
  end
  assign enter = enter_q;
`else
  localparam int debounce_unused = DEBOUNCE_CYCLES;
  logic btn_prev_q;
  always_ff @(posedge CLOCK_50 or negedge RESETN) begin
    if (!RESETN) btn_prev_q <= 1'b1;
    else btn_prev_q <= btn_s2_q;
  end
  assign enter = armed_q & btn_prev_q & ~btn_s2_q;
`endif
  // Enter pulses arriving in SEND fall through untouched: they are dropped, not queued.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    case (state_q)
      GET_A: if (enter) begin
        a_d     = sw_s2_q[3:0];
        state_d = GET_B;
      end
      GET_B: if (enter) begin
        b_d     = sw_s2_q[3:0];
        state_d = GET_OP;
      end
      GET_OP: if (enter) begin
        op_d    = sw_s2_q[2:0];
        state_d = SEND;
      end
      SEND: state_d = io.READY ? GET_A : SEND;
    endcase
  end
  always_ff @(posedge CLOCK_50 or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= GET_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
    end
  end
  assign io.A     = a_q;
  assign io.B     = b_q;
  assign io.OP    = op_q;
  assign io.VALID = (state_q == SEND);
  assign io.STATE = state_q;
endmodule

// File: tb/tb_calc_input_seq.sv
// tb_calc_input_seq: directed presses with a transfer scoreboard checked by an independent valid/ready monitor.
module tb_calc_input_seq;
  localparam int DC = 4;
`ifdef CALC_INPUT_SEQ_DEBOUNCE_EN
  localparam int LAT = 2 + DC + 1;
`else
  localparam int LAT = 3;
`endif
  typedef struct packed {logic [3:0] a; logic [3:0] b; logic [2:0] op;} txn_t;
  logic clk, resetn;
  int checks = 0, errors = 0, valid_cycles = 0;
  txn_t exp_q[$];
  calc_input_seq_if bus();
  calc_input_seq #(.DEBOUNCE_CYCLES(DC)) dut (.CLOCK_50(clk), .RESETN(resetn), .io(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic wait_change(output int lat);
    logic [1:0] s0;
    s0 = bus.STATE;
    lat = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (bus.STATE != s0) begin
        lat = i;
        break;
      end
    end
  endtask
  task automatic press(input logic [7:0] sw, input int exp_state);
    int lat;
    bus.SW = sw;
    bus.BTN_N = 1'b0;
    wait_change(lat);
    chk("press_latency", lat, LAT);
    chk("press_state", bus.STATE, exp_state);
    step(3);
    bus.BTN_N = 1'b1;
    step(DC + 6);
  endtask
  always @(negedge clk) begin
    if (resetn && bus.VALID) begin
      valid_cycles++;
      if (bus.READY) begin
        if (exp_q.size() == 0) chk("unexpected_transfer", 1, 0);
        else chk("transfer_abop", int'({bus.A, bus.B, bus.OP}), int'(exp_q.pop_front()));
      end
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int lat, v0;
    resetn = 1'b0;
    bus.SW = 8'h00;
    bus.BTN_N = 1'b1;
    bus.READY = 1'b1;
    step(3);
    chk("rst_a", bus.A, 0);
    chk("rst_b", bus.B, 0);
    chk("rst_op", bus.OP, 0);
    chk("rst_valid", bus.VALID, 0);
    chk("rst_state", bus.STATE, 0);
    resetn = 1'b1;
    step(5);
    exp_q.push_back('{a: 4'h4, b: 4'h3, op: 3'b000});
    press(8'h04, 1);
    chk("a_after_first", bus.A, 4);
    press(8'h03, 2);
    v0 = valid_cycles;
    press(8'h00, 3);
    chk("valid_one_cycle", valid_cycles - v0, 1);
    chk("state_after_send", bus.STATE, 0);
    press(8'h07, 1);
    press(8'h01, 2);
    resetn = 1'b0;
    #1;
    chk("midreset_a", bus.A, 0);
    chk("midreset_b", bus.B, 0);
    chk("midreset_op", bus.OP, 0);
    chk("midreset_valid", bus.VALID, 0);
    chk("midreset_state", bus.STATE, 0);
    step(3);
    resetn = 1'b1;
    step(5);
    bus.SW = 8'h06;
    bus.BTN_N = 1'b0;
    step(2);
    resetn = 1'b0;
    step(2);
    resetn = 1'b1;
    step(30);
    chk("held_through_reset", bus.STATE, 0);
    bus.BTN_N = 1'b1;
    step(DC + 6);
    chk("held_release", bus.STATE, 0);
    press(8'h0A, 1);
    press(8'h02, 2);
    bus.READY = 1'b0;
    exp_q.push_back('{a: 4'hA, b: 4'h2, op: 3'b101});
    press(8'h05, 3);
    bus.SW = 8'h0C;
    bus.BTN_N = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (i == DC + 4) bus.BTN_N = 1'b1;
      chk("stall_hold", int'({bus.STATE, bus.VALID, bus.A, bus.B, bus.OP}), int'({2'b11, 1'b1, 4'hA, 4'h2, 3'b101}));
    end
    bus.READY = 1'b1;
    step(1);
    chk("stall_release_state", bus.STATE, 0);
    step(DC + 6);
    chk("extra_press_ignored", bus.STATE, 0);
    chk("extra_press_a", bus.A, 10);
    bus.SW = 8'h05;
`ifdef CALC_INPUT_SEQ_DEBOUNCE_EN
    bus.BTN_N = 1'b0;
    step(2);
    bus.BTN_N = 1'b1;
    step(1);
    bus.BTN_N = 1'b0;
    step(2);
    bus.BTN_N = 1'b1;
    step(DC + 6);
    chk("bounce_state", bus.STATE, 0);
    chk("bounce_a", bus.A, 10);
`else
    bus.BTN_N = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) bus.BTN_N = 1'b1;
      if (bus.STATE != 2'b00) begin
        lat = i;
        break;
      end
    end
    chk("glitch_latency", lat, 3);
    chk("glitch_state", bus.STATE, 1);
    chk("glitch_a", bus.A, 5);
`endif
    resetn = 1'b0;
    step(2);
    resetn = 1'b1;
    step(5);
    chk("rereset_state", bus.STATE, 0);
    bus.SW = 8'hF9;
    bus.BTN_N = 1'b0;
    step(100);
    bus.BTN_N = 1'b1;
    step(DC + 6);
    chk("long_hold_state", bus.STATE, 1);
    chk("long_hold_a", bus.A, 9);
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/calc_input_seq.md
CALC_INPUT_SEQ -- requirements
Module: calc_input_seq

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 16, number of consecutive stable cycles that qualify a button press or release (legal range 2..1048575).
REQ-002 CLOCK_50  in  1  sole clock; all state updates on its rising edge.
REQ-003 RESETN  in  1  asynchronous, active-low reset.
REQ-004 SW  in  8  raw slide switches; SW[3:0] carry an operand, SW[2:0] carry an opcode.
REQ-005 BTN_N  in  1  raw enter pushbutton, active-low, bouncy, asynchronous to CLOCK_50.
REQ-006 READY  in  1  downstream calculator stage accepts the presented operation.
REQ-007 A  out  4  latched operand A, two's complement.
REQ-008 B  out  4  latched operand B, two's complement.
REQ-009 OP  out  3  latched opcode, same encoding as the calculator KEY input.
REQ-010 VALID  out  1  A/B/OP form a complete operation awaiting acceptance.
REQ-011 STATE  out  2  current sequencer state, for LED display.

Function
REQ-012 BTN_N and SW shall each pass through a two-flop synchronizer before any other use.
REQ-013 An internal one-cycle "enter" pulse shall be generated from the synchronized button per REQ-028/REQ-029.
REQ-014 States: GET_A=00, GET_B=01, GET_OP=10, SEND=11; STATE shall equal the current state code.
REQ-015 GET_A + enter -> A <= synchronized SW[3:0], next state GET_B.
REQ-016 GET_B + enter -> B <= synchronized SW[3:0], next state GET_OP.
REQ-017 GET_OP + enter -> OP <= synchronized SW[2:0], next state SEND.
REQ-018 SEND: VALID=1, combinationally decoded from state only.
REQ-019 In SEND, transfer occurs at the rising edge where VALID and READY are both 1. Next state is GET_A, so VALID is 0 the following cycle.
REQ-020 In SEND with READY=0, the block shall hold the state, and A, B, OP and VALID shall remain constant.
REQ-021 Enter pulses in SEND shall be discarded, not queued.
REQ-022 A, B and OP shall hold their last latched values after transfer until overwritten by the next entry.
REQ-023 The register update shall occur on the edge following the enter pulse. Latency from the BTN_N falling edge to the STATE change is 2 + DEBOUNCE_CYCLES + 1 cycles with debounce, and 3 cycles without.
REQ-024 A held button shall produce exactly one enter pulse per press, regardless of hold duration.

Reset
REQ-025 RESETN low shall immediately force A=0, B=0, OP=0, VALID=0, STATE=GET_A.
REQ-026 RESETN low shall clear debounce counters. Button synchronizer flops shall reset to 1 (released) and SW synchronizer flops to 0.
REQ-027 Reset asserted mid-entry or in SEND shall abandon the partial operation with no transfer. After release, the block shall wait in GET_A, and a button held through reset shall not produce an enter pulse until it has been released.

Configuration
REQ-028 With CALC_INPUT_SEQ_DEBOUNCE_EN defined:
- A saturating counter shall count consecutive cycles in which the synchronized level differs from the debounced level, and shall clear whenever the levels match.
- At DEBOUNCE_CYCLES the debounced level shall flip.
- A 1->0 flip of the debounced level shall emit one enter pulse.
REQ-029 Without CALC_INPUT_SEQ_DEBOUNCE_EN, enter shall be the falling-edge detect of the synchronized BTN_N (any 1->0 transition, including single-cycle glitches). No debounce counter shall exist.

Verification
REQ-030 Macro on, DEBOUNCE_CYCLES=4, READY=1:
- Stimulus: clean presses with SW=0x04, then 0x03, then 0x00.
- Response: VALID high exactly 1 cycle with A=4, B=3, OP=000; STATE sequence 00->01->10->11->00.
REQ-031 Macro on, READY=0 for 10 cycles in SEND, extra press during that time:
- Response: VALID=1 and A/B/OP constant throughout; STATE stays 11.
- Then READY=1: transfer occurs, STATE=00, and the extra press has no effect.
REQ-032 Macro on, DEBOUNCE_CYCLES=4, bounce pattern BTN_N low 2 cycles, high 1, low 2, then high:
- Response: no enter pulse; STATE stays 00.
REQ-033 Macro on, BTN_N held low 100 cycles with SW=0xF9:
- Response: exactly one advance, A=4'b1001 (-7); STATE=01.
REQ-034 RESETN pulsed low while in GET_OP with A=7, B=1:
- Response: A, B, OP and VALID go to 0 and STATE to 00 before the next clock edge.
REQ-035 Macro off, single-cycle BTN_N low glitch in GET_A with SW=0x05:
- Response: A=5 and STATE=01, 3 cycles after the glitch.
